core_regfile_p: RTL
===================

CORE_REGFILE_P -- requirements
Module: core_regfile_p

Interface
REQ-001 Parameter XLEN, default 32, register and PC width.
REQ-002 Parameter NREG, default 32, register count (power of two, >=2); AW = log2(NREG).
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 Parameter INW, default 8, input-port write width (1..XLEN).
REQ-005 Port CLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 Port RST  in  1  reset; synchronous, active-high.
REQ-007 Port WE  in  1  full-width write request.
REQ-008 Port WADDR  in  AW  write address, shared by WE and INE.
REQ-009 Port WDATA  in  XLEN  full-width write data.
REQ-010 Port INE  in  1  input-port write request, low INW bits only.
REQ-011 Port INDATA  in  INW  input-port data.
REQ-012 Port RSADDR  in  NRD*AW  packed read addresses; port i at [i*AW +: AW].
REQ-013 Port RS_EN  in  NRD  per-port read enable.
REQ-014 Port RS  out  NRD*XLEN  packed registered read data; port i at [i*XLEN +: XLEN].
REQ-015 Port WR_PEND  out  1  high while a captured write awaits commit.
REQ-016 Port PC_WE  in  1  PC load.
REQ-017 Port PC_INC  in  1  PC increment by 4.
REQ-018 Port PC_WDATA  in  XLEN  PC load value.
REQ-019 Port PC  out  XLEN  program counter.

Function
REQ-020 Write stage: on an edge with WE or INE high, the block SHALL capture WE, INE, WADDR, WDATA and INDATA into a one-entry write stage; the entry SHALL commit on the following edge, giving a commit latency of 1 cycle.
REQ-021 WR_PEND SHALL equal the write-stage valid bit, which is (captured WE or captured INE).
REQ-022 A commit with captured WE SHALL write WDATA to the addressed register.
REQ-023 A commit with captured INE only SHALL write {reg[XLEN-1:INW], INDATA} to the addressed register; when INW==XLEN, INDATA alone is written.
REQ-024 If WE and INE are high together, WE SHALL take priority and INE SHALL be ignored.
REQ-025 Back-to-back requests SHALL be accepted every cycle with no stall, and each SHALL commit in order.
REQ-026 Register 0 SHALL read as zero; commits to address 0 SHALL be discarded.
REQ-027 Read: on an edge with RS_EN[i] high, RS port i SHALL load the register at RSADDR[i]; with RS_EN[i] low, port i SHALL hold its value.
REQ-028 Read bypass: if the write stage commits on the same edge to the same nonzero address, RS port i SHALL load the post-commit value, including the INE byte merge.
REQ-029 Read ports SHALL be independent; identical addresses on several ports SHALL return identical data.
REQ-030 PC: PC_WE SHALL load PC_WDATA; otherwise PC_INC SHALL add 4, modulo 2^XLEN, wrapping silently; PC_WE SHALL have priority over PC_INC; with neither high, PC SHALL hold.

Reset
REQ-031 While RST is high at an edge, the block SHALL clear all registers, all RS ports, PC and the write-stage valid bit to 0, overriding every other input.
REQ-032 A write captured in the cycle before RST SHALL be dropped and SHALL not commit after reset is released.
REQ-033 The first request accepted after RST falls SHALL behave exactly as in REQ-020.

Structure
REQ-034 A shared package SHALL hold the write-stage record type (we, ine, addr, wdata, indata), the PC step constant 4, and the AW derivation function.
REQ-035 One sub-module, core_regfile_rdport, SHALL implement a single registered read port with bypass, instantiated NRD times by generate.
REQ-036 The register array SHALL use no vendor memory primitive, because a synchronous clear of every entry on reset is required.

Verification
REQ-037 WE=1, WADDR=5, WDATA=0xDEADBEEF at edge k; RSADDR0=5, RS_EN0=1 at edge k+1 -> RS0=0xDEADBEEF after k+1 via bypass, and WR_PEND=1 during cycle k..k+1.
REQ-038 x5=0x12345678, then INE=1, INDATA=0xAB to address 5 -> x5 reads 0x123456AB; WE and INE together with WDATA=0x1 -> x5 reads 0x00000001.
REQ-039 WE to address 0 with WDATA=0xFFFFFFFF, then read on both ports at address 0 -> RS0=RS1=0.
REQ-040 Write 0xA to address 3, then RS_EN0=0 while address 3 is written 0xB -> RS0 stays at the old value until RS_EN0=1, then reads 0xB.
REQ-041 WE to address 7 at edge k, RST=1 at edge k+1 -> x7=0 and WR_PEND=0 after reset; PC_WDATA=0xFFFFFFFC load followed by PC_INC -> PC=0x00000000.
REQ-042 Parameter sweep with NREG=16, NRD=3, XLEN=64, INW=16 -> REQ-037 through REQ-041 pass with widths scaled accordingly.

Source files
------------

// File: rtl/core_regfile_p_pkg.sv
// Shared types and constants for the core register file slice.
// The write-stage record is sized for the widest supported configuration
// (XLEN, INW up to 64 bits, up to 2^16 registers); instances use the low bits.
package core_regfile_p_pkg;

  localparam int unsigned MAX_XLEN = 64;
  localparam int unsigned MAX_INW  = 64;
  localparam int unsigned MAX_AW   = 16;

  // Program counter advances by one 32-bit instruction word.
  localparam int unsigned PC_STEP = 4;

  // One captured write request awaiting commit.
  typedef struct packed {
    logic                we;
    logic                ine;
    logic [MAX_AW-1:0]   addr;
    logic [MAX_XLEN-1:0] wdata;
    logic [MAX_INW-1:0]  indata;
  } wstage_t;

  // Address width for n registers: ceil(log2(n)), never less than 1.
  function automatic int unsigned addr_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/core_regfile_rdport.sv
// Single registered read port. Loads the array word on enable, or the value
// being committed on this same edge when it targets the addressed register.
module core_regfile_rdport
  import core_regfile_p_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] array_data,
  input  logic            commit_en,
  input  logic [AW-1:0]   commit_addr,
  input  logic [XLEN-1:0] commit_data,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] data_reg;
  logic [XLEN-1:0] data_next;
  logic            bypass;

  // commit_en is already suppressed for register 0, so x0 never bypasses.
  assign bypass = commit_en && (commit_addr == addr);

  // Select the post-commit value when the write lands on our address.
  always_comb begin
    data_next = bypass ? commit_data : array_data;
  end

  // Output register: clears on reset, loads on enable, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= '0;
    end else if (en) begin
      data_reg <= data_next;
    end
  end

  assign data = data_reg;

endmodule

// File: rtl/core_regfile_p.sv
// Core register file: one-entry write stage (full-width and low-byte input
// port writes), NRD registered read ports with commit bypass, and the PC.
module core_regfile_p
  import core_regfile_p_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2,
  parameter int unsigned INW  = 8,
  parameter int unsigned AW   = addr_width(NREG)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WE,
  input  logic [AW-1:0]       WADDR,
  input  logic [XLEN-1:0]     WDATA,
  input  logic                INE,
  input  logic [INW-1:0]      INDATA,
  input  logic [NRD*AW-1:0]   RSADDR,
  input  logic [NRD-1:0]      RS_EN,
  output logic [NRD*XLEN-1:0] RS,
  output logic                WR_PEND,
  input  logic                PC_WE,
  input  logic                PC_INC,
  input  logic [XLEN-1:0]     PC_WDATA,
  output logic [XLEN-1:0]     PC
);

  // Masks selecting the live bits of the wide write-stage record.
  localparam logic [MAX_XLEN-1:0] DATA_MASK = {MAX_XLEN{1'b1}} >> (MAX_XLEN - XLEN);
  localparam logic [MAX_INW-1:0]  IN_MASK   = {MAX_INW{1'b1}} >> (MAX_INW - INW);
  localparam logic [MAX_AW-1:0]   ADDR_MASK = {MAX_AW{1'b1}} >> (MAX_AW - AW);
  // Bits of a register replaced by an input-port write.
  localparam logic [XLEN-1:0]     MERGE_MASK = {XLEN{1'b1}} >> (XLEN - INW);

  // ---------------------------------------------------------------------
  // Write stage
  // ---------------------------------------------------------------------
  wstage_t ws_reg;
  wstage_t ws_next;

  // Capture any request; an idle cycle empties the stage.
  always_comb begin
    ws_next = '0;
    if (WE || INE) begin
      ws_next.we                = WE;
      ws_next.ine               = INE;
      ws_next.addr[AW-1:0]      = WADDR;
      ws_next.wdata[XLEN-1:0]   = WDATA;
      ws_next.indata[INW-1:0]   = INDATA;
    end
  end

  // Stage register; reset drops any write still waiting to commit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ws_reg <= '0;
    end else begin
      ws_reg <= ws_next;
    end
  end

  assign WR_PEND = ws_reg.we | ws_reg.ine;

  // Padding bits of the record are constant zero; fold them away explicitly.
  logic unused_ws_pad;
  assign unused_ws_pad = ^{ws_reg.wdata & ~DATA_MASK,
                           ws_reg.indata & ~IN_MASK,
                           ws_reg.addr & ~ADDR_MASK};

  // ---------------------------------------------------------------------
  // Commit path
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] regs_reg [NREG];
  logic [AW-1:0]   commit_addr;
  logic            commit_en;
  logic [XLEN-1:0] commit_old;
  logic [XLEN-1:0] commit_data;

  assign commit_addr = ws_reg.addr[AW-1:0];
  assign commit_en   = WR_PEND && (commit_addr != '0);
  assign commit_old  = regs_reg[commit_addr];

  // WE wins over INE; an input-port write keeps the upper register bits.
  always_comb begin
    if (ws_reg.we) begin
      commit_data = ws_reg.wdata[XLEN-1:0];
    end else begin
      commit_data = (commit_old & ~MERGE_MASK) | XLEN'(ws_reg.indata[INW-1:0]);
    end
  end

  // Register array with synchronous clear; x0 is never written.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_reg[i] <= '0;
      end
    end else if (commit_en) begin
      regs_reg[commit_addr] <= commit_data;
    end
  end

  // ---------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < int'(NRD); gi++) begin : g_rd
      logic [AW-1:0]   rd_addr;
      logic [XLEN-1:0] rd_array;

      assign rd_addr  = RSADDR[gi*AW +: AW];
      assign rd_array = regs_reg[rd_addr];

      core_regfile_rdport #(
        .XLEN (XLEN),
        .AW   (AW)
      ) u_rdport (
        .clk         (CLK),
        .rst         (RST),
        .en          (RS_EN[gi]),
        .addr        (rd_addr),
        .array_data  (rd_array),
        .commit_en   (commit_en),
        .commit_addr (commit_addr),
        .commit_data (commit_data),
        .data        (RS[gi*XLEN +: XLEN])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Program counter
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_next;

  // Load beats increment; the increment wraps silently at 2^XLEN.
  always_comb begin
    pc_next = pc_reg;
    if (PC_WE) begin
      pc_next = PC_WDATA;
    end else if (PC_INC) begin
      pc_next = pc_reg + XLEN'(PC_STEP);
    end
  end

  // PC register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_reg <= '0;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign PC = pc_reg;

endmodule
